// File: rtl/calc_operand_entry.sv
// calc_operand_entry: operand entry front-end for the switch/button calculator.
// Synchronizes the switches and buttons, debounces both buttons, and steps a
// four-state entry FSM that captures sign/magnitude A, sign/magnitude B and
// the operation select in turn.
// Optional feature: define CALC_NEG_ZERO_FIX_EN to force the captured sign of
// a zero magnitude to 0 (canonical zero); otherwise -0 is passed through.
module calc_operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_val,
    input  logic       sw_sign,
    input  logic [1:0] sw_sel,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic       signA,
    output logic [3:0] A,
    output logic       signB,
    output logic [3:0] B,
    output logic [1:0] sel,
    output logic       operands_valid,
    output logic [1:0] entry_state
);

    // Counter runs 0..DEBOUNCE_CYCLES-1; the level flips on the last count.
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam int unsigned BTN_ENTER = 0;
    localparam int unsigned BTN_CLEAR = 1;

    typedef enum logic [1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        WAIT_OP = 2'b10,
        READY   = 2'b11
    } state_t;

    // Synchronizer stages
    logic [3:0] sw_val_s1, sw_val_s;
    logic       sw_sign_s1, sw_sign_s;
    logic [1:0] sw_sel_s1, sw_sel_s;
    logic [1:0] btn_s1, btn_s;

    // Debouncer state
    logic [1:0]    deb_q;
    logic [1:0]    deb_d;
    logic [CW-1:0] cnt_q [2];
    logic [1:0]    press;

    // FSM state and registered outputs
    state_t     state_q, state_n;
    logic       signA_q, signA_n;
    logic [3:0] A_q, A_n;
    logic       signB_q, signB_n;
    logic [3:0] B_q, B_n;
    logic [1:0] sel_q, sel_n;
    logic       valid_q;
    logic       cap_sign;

    // Two-flop synchronizers for every asynchronous input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_val_s1  <= '0;
            sw_val_s   <= '0;
            sw_sign_s1 <= 1'b0;
            sw_sign_s  <= 1'b0;
            sw_sel_s1  <= '0;
            sw_sel_s   <= '0;
            btn_s1     <= '0;
            btn_s      <= '0;
        end else begin
            sw_val_s1  <= sw_val;
            sw_val_s   <= sw_val_s1;
            sw_sign_s1 <= sw_sign;
            sw_sign_s  <= sw_sign_s1;
            sw_sel_s1  <= sw_sel;
            sw_sel_s   <= sw_sel_s1;
            btn_s1     <= {btn_clear, btn_enter};
            btn_s      <= btn_s1;
        end
    end

    // Per-button debouncer: accept a level only after it has been stable and
    // different from the current level for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_q <= '0;
            deb_d <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_d <= deb_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (btn_s[i] != deb_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        deb_q[i] <= btn_s[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    // One-cycle press pulse on the debounced rising edge only
    always_comb begin
        press = deb_q & ~deb_d;
    end

    // Sign value to capture, optionally canonicalising -0 to +0
    always_comb begin
`ifdef CALC_NEG_ZERO_FIX_EN
        cap_sign = sw_sign_s & (|sw_val_s);
`else
        cap_sign = sw_sign_s;
`endif
    end

    // Entry FSM register and captured operand registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WAIT_A;
            signA_q <= 1'b0;
            A_q     <= '0;
            signB_q <= 1'b0;
            B_q     <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            signA_q <= signA_n;
            A_q     <= A_n;
            signB_q <= signB_n;
            B_q     <= B_n;
            sel_q   <= sel_n;
            valid_q <= (state_n == READY);
        end
    end

    // Entry FSM next-state and capture decisions; clear overrides enter
    always_comb begin
        state_n = state_q;
        signA_n = signA_q;
        A_n     = A_q;
        signB_n = signB_q;
        B_n     = B_q;
        sel_n   = sel_q;
        if (press[BTN_CLEAR]) begin
            state_n = WAIT_A;
            signA_n = 1'b0;
            A_n     = '0;
            signB_n = 1'b0;
            B_n     = '0;
            sel_n   = '0;
        end else if (press[BTN_ENTER]) begin
            unique case (state_q)
                WAIT_A: begin
                    signA_n = cap_sign;
                    A_n     = sw_val_s;
                    state_n = WAIT_B;
                end
                WAIT_B: begin
                    signB_n = cap_sign;
                    B_n     = sw_val_s;
                    state_n = WAIT_OP;
                end
                WAIT_OP: begin
                    sel_n   = sw_sel_s;
                    state_n = READY;
                end
                READY: begin
                    // Chained entry: new A starts a fresh expression
                    signA_n = cap_sign;
                    A_n     = sw_val_s;
                    signB_n = 1'b0;
                    B_n     = '0;
                    sel_n   = '0;
                    state_n = WAIT_B;
                end
                default: state_n = WAIT_A;
            endcase
        end
    end

    assign signA          = signA_q;
    assign A              = A_q;
    assign signB          = signB_q;
    assign B              = B_q;
    assign sel            = sel_q;
    assign operands_valid = valid_q;
    assign entry_state    = state_q;

endmodule

// File: doc/calc_operand_entry.md
CALC_OPERAND_ENTRY -- requirements
Module: calc_operand_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive stable synchronized cycles needed before a button level change is accepted.
REQ-002 clk  input  1  Single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  Reset, synchronous and active-low.
REQ-004 sw_val  input  4  Magnitude switches; asynchronous.
REQ-005 sw_sign  input  1  Sign switch, 1 = negative; asynchronous.
REQ-006 sw_sel  input  2  Operation-select switches; asynchronous.
REQ-007 btn_enter  input  1  Raw enter button, active-high, bouncing.
REQ-008 btn_clear  input  1  Raw clear button, active-high, bouncing.
REQ-009 signA  output  1  Captured sign of operand A, registered.
REQ-010 A  output  4  Captured magnitude of operand A, registered.
REQ-011 signB  output  1  Captured sign of operand B, registered.
REQ-012 B  output  4  Captured magnitude of operand B, registered.
REQ-013 sel  output  2  Captured operation select, registered.
REQ-014 operands_valid  output  1  High while all three fields are captured; drives the downstream calculator.
REQ-015 entry_state  output  2  Current FSM state for LEDs: 00 WAIT_A, 01 WAIT_B, 10 WAIT_OP, 11 READY.

Function
REQ-016 The block SHALL pass sw_val, sw_sign, sw_sel, btn_enter and btn_clear through 2-flop synchronizers before any other use.
REQ-017 Each button SHALL have its own debouncer: the debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap resets the count to 0.
REQ-018 A press SHALL be a one-cycle pulse on the debounced 0->1 edge; the 1->0 edge produces no pulse.
REQ-019 On an enter press in WAIT_A, the block SHALL load signA/A from the synchronized switches at that edge and go to WAIT_B.
REQ-020 On an enter press in WAIT_B, the block SHALL load signB/B and go to WAIT_OP.
REQ-021 On an enter press in WAIT_OP, the block SHALL load sel from synchronized sw_sel and go to READY.
REQ-022 On an enter press in READY, the block SHALL load a new signA/A, clear signB/B/sel to 0 and go to WAIT_B, so results can be chained.
REQ-023 operands_valid SHALL be 1 exactly when the state is READY and SHALL be registered, never decoded through combinational logic from the inputs.
REQ-024 A clear press in any state SHALL zero all operand outputs and go to WAIT_A.
REQ-025 If clear and enter presses occur in the same cycle, clear SHALL win and the enter press SHALL be discarded.
REQ-026 Without presses, all outputs SHALL hold; switch movement alone SHALL change no output.
REQ-027 Latency: outputs SHALL reflect a capture on the cycle after the press pulse.

Reset
REQ-028 While rst_n is low at a clock edge, the block SHALL set state WAIT_A, all operand outputs 0, operands_valid 0, all synchronizer and debounced levels 0, and both debounce counters 0.
REQ-029 Reset asserted mid-debounce or mid-entry SHALL discard partial operands; an enter button held through reset release SHALL produce one press only after DEBOUNCE_CYCLES stable cycles.

Configuration
REQ-030 With CALC_NEG_ZERO_FIX_EN defined, a captured sign SHALL be forced to 0 whenever its captured magnitude is 0 (canonical zero).
REQ-031 Without CALC_NEG_ZERO_FIX_EN, the sign bit SHALL be captured exactly as switched, so -0 is passed downstream.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-032 Scenario: clean presses; A=0101 with sign 1, B=0111 with sign 0, sel=10 -> signA=1, A=0101, signB=0, B=0111, sel=10, operands_valid=1, entry_state=11.
REQ-033 Scenario: enter bounces 1-0-1-0 at 2-cycle intervals, then stays high for 10 cycles -> exactly one capture and one state advance.
REQ-034 Scenario: in READY, press clear and enter in the same cycle -> all outputs 0, state WAIT_A, operands_valid=0.
REQ-035 Scenario: in READY, enter press with sw_val=0011 and sign 0 -> A=0011, B=0, sel=0, state WAIT_B, operands_valid falls the next cycle.
REQ-036 Scenario: capture magnitude 0000 with sign 1 -> signA=0 with CALC_NEG_ZERO_FIX_EN defined, signA=1 without it.
REQ-037 Scenario: rst_n low for one edge while in WAIT_OP -> all outputs 0 and state 00 on the next cycle.
